// File: rtl/axi4_mem_slave.sv
// AXI4 memory-mapped slave backed by a word-wide RAM.
// Independent single-outstanding write and read burst engines.
module axi4_mem_slave #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic              wlast,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast
);

    localparam int NB    = DATA_W / 8;
    localparam int LNB   = $clog2(NB);
    localparam int MW_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_W-1:0] MEM_LIM = ADDR_W'(MEM_WORDS);
    localparam logic [2:0] LNB3 = 3'(LNB);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        sz,
        input logic [1:0]        bt
    );
        logic [ADDR_W-1:0] step;
        step = ADDR_W'(1) << sz;
        if (bt == 2'b01)
            return (a & ~(step - ADDR_W'(1))) + step;
        return a;
    endfunction

    // WRAP/reserved bursts and beats wider than the bus are rejected
    function automatic logic bad_type(input logic [1:0] bt, input logic [2:0] sz);
        return bt[1] | (sz > LNB3);
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // write path
    logic [1:0]        w_state;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_dec;
    logic              w_slv;

    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic [ADDR_W-1:0] w_idx;
    logic              w_oob;
    logic              w_bad;
    logic              w_beat_last;
    logic              w_dec_nxt;
    logic              w_slv_nxt;
    logic              w_we;

    always_comb begin
        aw_hs       = awvalid & awready;
        w_hs        = wvalid & wready;
        b_hs        = bvalid & bready;
        w_idx       = w_addr >> LNB;
        w_oob       = (w_idx >= MEM_LIM);
        w_bad       = bad_type(w_burst, w_size);
        w_beat_last = (w_cnt == w_len);
        w_dec_nxt   = w_dec | w_oob;
        w_slv_nxt   = w_slv | w_bad | (wlast != w_beat_last);
        w_we        = w_hs & ~w_oob & ~w_bad;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= ~aw_hs;
                    if (aw_hs) begin
                        w_id    <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_dec   <= 1'b0;
                        w_slv   <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_dec  <= w_dec_nxt;
                        w_slv  <= w_slv_nxt;
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_beat_last) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= w_dec_nxt ? RESP_DECERR :
                                       w_slv_nxt ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b])
                    mem[w_idx[MW_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // read path
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    logic              ar_hs;
    logic              r_hs;
    logic              r_fetch;
    logic [ADDR_W-1:0] f_addr;
    logic [ADDR_W-1:0] f_idx;
    logic [2:0]        f_size;
    logic [1:0]        f_burst;
    logic [7:0]        f_cnt;
    logic [7:0]        f_len;
    logic              f_oob;
    logic              f_bad;
    logic [DATA_W-1:0] f_word;
    logic [DATA_W-1:0] f_data;
    logic [1:0]        f_resp;

    always_comb begin
        ar_hs   = arvalid & arready;
        r_hs    = rvalid & rready;
        r_fetch = ar_hs | (r_hs & ~rlast);
        f_addr  = ar_hs ? araddr  : next_addr(r_addr, r_size, r_burst);
        f_size  = ar_hs ? arsize  : r_size;
        f_burst = ar_hs ? arburst : r_burst;
        f_cnt   = ar_hs ? 8'd0    : r_cnt + 8'd1;
        f_len   = ar_hs ? arlen   : r_len;
        f_idx   = f_addr >> LNB;
        f_oob   = (f_idx >= MEM_LIM);
        f_bad   = bad_type(f_burst, f_size);
        f_word  = mem[f_idx[MW_AW-1:0]];
        f_data  = (f_oob | f_bad) ? '0 : f_word;
        f_resp  = f_oob ? RESP_DECERR : f_bad ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            rid     <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            if (r_fetch) begin
                r_addr <= f_addr;
                r_cnt  <= f_cnt;
                rlast  <= (f_cnt == f_len);
                rresp  <= f_resp;
                rdata  <= f_data;
            end
            case (r_state)
                R_IDLE: begin
                    arready <= ~ar_hs;
                    if (ar_hs) begin
                        rid     <= arid;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        rvalid  <= 1'b1;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs && rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
